// File: rtl/rv32v_reduction_sequencer.sv
// rtl/rv32v_reduction_sequencer.sv - walks a vector reduction across 4-lane VRF beats
// and folds each beat result into a scalar accumulator seeded with vs1[0].
module rv32v_reduction_sequencer #(
   parameter int VL_W   = 8,
   parameter int BEAT_W = VL_W - 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic              abort,
   input  logic [3:0]        valuop,
   input  logic              vopunsigned,
   input  logic              vm,
   input  logic [VL_W-1:0]   vl,
   input  logic [31:0]       scalar_in,
   output logic              busy,
   output logic              rd_req,
   output logic [BEAT_W-1:0] rd_idx,
   input  logic              rd_valid,
   input  logic [127:0]      rd_data,
   input  logic [3:0]        rd_mask,
   output logic [3:0]        red_valuop,
   output logic              red_vopunsigned,
   output logic [127:0]      red_vdat,
   output logic [3:0]        red_vmask,
   input  logic [31:0]       red_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic              out_wen,
   output logic              out_err
);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_MAX = 4'd1;
   localparam logic [3:0] OP_MIN = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4;
   localparam logic [3:0] OP_XOR = 4'd5;

   typedef enum logic [1:0] {IDLE, READ, ACCUM, DONE} state_t;

   state_t            state;
   logic [3:0]        op_q;
   logic              uns_q;
   logic              vm_q;
   logic [VL_W-1:0]   vl_q;
   logic [31:0]       acc;
   logic [BEAT_W-1:0] beat;
   logic [127:0]      data_q;
   logic [3:0]        mask_q;

   logic [VL_W-1:0]   last_beat;
   logic              is_last;
   logic [3:0]        lane_act;
   logic [31:0]       ident;
   logic              res_gt;
   logic              res_lt;
   logic [31:0]       acc_next;

   assign last_beat = (vl_q - VL_W'(1)) >> 2;
   assign is_last   = (VL_W'(beat) == last_beat);

   // A lane contributes only if it is unmasked and below vl; tail lanes get the identity.
   always_comb begin
      lane_act = '0;
      for (int i = 0; i < 4; i++) begin
         lane_act[i] = (vm_q || mask_q[i]) && ({beat, 2'(i)} < {1'b0, vl_q});
      end
   end

   always_comb begin
      case (op_q)
         OP_AND:  ident = 32'hFFFF_FFFF;
         OP_MAX:  ident = uns_q ? 32'h0000_0000 : 32'h8000_0000;
         OP_MIN:  ident = uns_q ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
         default: ident = 32'h0000_0000;
      endcase
   end

   always_comb begin
      red_vmask       = 4'hF;
      red_valuop      = OP_ADD;
      red_vopunsigned = 1'b0;
      red_vdat        = '0;
      if (state == ACCUM) begin
         red_valuop      = op_q;
         red_vopunsigned = uns_q;
         for (int i = 0; i < 4; i++) begin
            red_vdat[32*i +: 32] = lane_act[i] ? data_q[32*i +: 32] : ident;
         end
      end
   end

   assign res_gt = uns_q ? (red_result > acc) : ($signed(red_result) > $signed(acc));
   assign res_lt = uns_q ? (red_result < acc) : ($signed(red_result) < $signed(acc));

   always_comb begin
      case (op_q)
         OP_ADD:  acc_next = acc + red_result;
         OP_MAX:  acc_next = res_gt ? red_result : acc;
         OP_MIN:  acc_next = res_lt ? red_result : acc;
         OP_AND:  acc_next = acc & red_result;
         OP_OR:   acc_next = acc | red_result;
         OP_XOR:  acc_next = acc ^ red_result;
         default: acc_next = acc;
      endcase
      if (lane_act == 4'b0000) begin
         acc_next = acc;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         busy      <= 1'b0;
         rd_req    <= 1'b0;
         rd_idx    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_wen   <= 1'b0;
         out_err   <= 1'b0;
         acc       <= '0;
         beat      <= '0;
         op_q      <= OP_ADD;
         uns_q     <= 1'b0;
         vm_q      <= 1'b0;
         vl_q      <= '0;
         data_q    <= '0;
         mask_q    <= '0;
      end else if (abort) begin
         state     <= IDLE;
         busy      <= 1'b0;
         rd_req    <= 1'b0;
         out_valid <= 1'b0;
         out_wen   <= 1'b0;
         out_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_q  <= valuop;
                  uns_q <= vopunsigned;
                  vm_q  <= vm;
                  vl_q  <= vl;
                  acc   <= scalar_in;
                  beat  <= '0;
                  busy  <= 1'b1;
                  if (valuop > OP_XOR) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     out_data  <= scalar_in;
                     out_wen   <= 1'b0;
                     out_err   <= 1'b1;
                  end else if (vl == '0) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     out_data  <= scalar_in;
                     out_wen   <= 1'b0;
                     out_err   <= 1'b0;
                  end else begin
                     state  <= READ;
                     rd_req <= 1'b1;
                     rd_idx <= '0;
                  end
               end
            end
            READ: begin
               if (rd_valid) begin
                  data_q <= rd_data;
                  mask_q <= rd_mask;
                  rd_req <= 1'b0;
                  state  <= ACCUM;
               end
            end
            ACCUM: begin
               acc  <= acc_next;
               beat <= beat + BEAT_W'(1);
               if (is_last) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  out_data  <= acc_next;
                  out_wen   <= 1'b1;
                  out_err   <= 1'b0;
               end else begin
                  state  <= READ;
                  rd_req <= 1'b1;
                  rd_idx <= beat + BEAT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  out_valid <= 1'b0;
                  out_wen   <= 1'b0;
                  out_err   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32v_reduction_sequencer.sv
// tb/tb_rv32v_reduction_sequencer.sv - directed bench with an element-level reduction model
module tb_rv32v_reduction_sequencer;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_MAX = 4'd1;
   localparam logic [3:0] OP_MIN = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4;
   localparam logic [3:0] OP_XOR = 4'd5;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [3:0]   valuop = 4'd0;
   logic         vopunsigned = 1'b0;
   logic         vm = 1'b0;
   logic [7:0]   vl = 8'd0;
   logic [31:0]  scalar_in = 32'd0;
   logic         busy;
   logic         rd_req;
   logic [6:0]   rd_idx;
   logic         rd_valid = 1'b0;
   logic [127:0] rd_data = '0;
   logic [3:0]   rd_mask = 4'd0;
   logic [3:0]   red_valuop;
   logic         red_vopunsigned;
   logic [127:0] red_vdat;
   logic [3:0]   red_vmask;
   logic [31:0]  red_result;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [31:0]  out_data;
   logic         out_wen;
   logic         out_err;

   always #5 CLK = ~CLK;

   rv32v_reduction_sequencer #(.VL_W(8), .BEAT_W(7)) dut (
      .CLK(CLK), .RST(RST), .start(start), .abort(abort),
      .valuop(valuop), .vopunsigned(vopunsigned), .vm(vm), .vl(vl), .scalar_in(scalar_in),
      .busy(busy), .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid),
      .rd_data(rd_data), .rd_mask(rd_mask),
      .red_valuop(red_valuop), .red_vopunsigned(red_vopunsigned), .red_vdat(red_vdat),
      .red_vmask(red_vmask), .red_result(red_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_wen(out_wen), .out_err(out_err)
   );

   logic [31:0] elem [0:255];
   bit          mbit [0:255];

   int n_checks = 0;
   int n_fail = 0;

   logic [3:0]  cur_op = 4'd0;
   bit          cur_uns = 1'b0;
   bit          cur_vm = 1'b0;
   int          cur_vl = 0;
   logic [31:0] exp_data = 32'd0;
   bit          exp_wen = 1'b0;
   bit          exp_err = 1'b0;
   bit          exp_running = 1'b0;
   int          exp_beats = 0;
   int          exp_beat = 0;
   int          rd_delay = 0;
   int          wait_cnt = 0;
   int          reads = 0;
   int          vbeat = 0;

   function automatic logic [31:0] comb(input logic [3:0] op, input bit u,
                                        input logic [31:0] a, input logic [31:0] b);
      case (op)
         OP_ADD: return a + b;
         OP_MAX: return u ? ((a > b) ? a : b) : (($signed(a) > $signed(b)) ? a : b);
         OP_MIN: return u ? ((a < b) ? a : b) : (($signed(a) < $signed(b)) ? a : b);
         OP_AND: return a & b;
         OP_OR:  return a | b;
         OP_XOR: return a ^ b;
         default: return a;
      endcase
   endfunction

   function automatic logic [31:0] ident(input logic [3:0] op, input bit u);
      case (op)
         OP_AND: return 32'hFFFF_FFFF;
         OP_MAX: return u ? 32'h0000_0000 : 32'h8000_0000;
         OP_MIN: return u ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
         default: return 32'h0000_0000;
      endcase
   endfunction

   // Whole-instruction result straight from the element list.
   function automatic logic [31:0] model(input logic [3:0] op, input bit u, input bit v,
                                         input int n, input logic [31:0] sc);
      logic [31:0] a;
      a = sc;
      if (op > OP_XOR) return sc;
      for (int k = 0; k < n; k++) begin
         if (v || mbit[k]) a = comb(op, u, a, elem[k]);
      end
      return a;
   endfunction

   function automatic logic [31:0] lane_exp(input int e);
      if ((cur_vm || mbit[e]) && e < cur_vl) return elem[e];
      return ident(cur_op, cur_uns);
   endfunction

   // Reduction unit stand-in.
   always_comb begin
      red_result = ident(red_valuop, red_vopunsigned);
      for (int i = 0; i < 4; i++) begin
         if (red_vmask[i]) red_result = comb(red_valuop, red_vopunsigned, red_result, red_vdat[32*i +: 32]);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic clear_mem();
      for (int k = 0; k < 256; k++) begin
         elem[k] = 32'hDEAD_0000 + 32'(k);
         mbit[k] = 1'b0;
      end
   endtask

   // VRF responder and per-cycle output checker.
   initial begin
      forever begin
         @(negedge CLK);
         if (!RST) begin
            if (rd_valid) begin
               rd_valid = 1'b0;
               reads++;
               for (int i = 0; i < 4; i++) begin
                  check($sformatf("red_vdat_lane%0d_beat%0d", i, vbeat), red_vdat[32*i +: 32], lane_exp(4*vbeat + i));
               end
               check("red_valuop", {28'd0, red_valuop}, {28'd0, cur_op});
               check("red_vopunsigned", {31'd0, red_vopunsigned}, {31'd0, cur_uns});
               check("red_vmask", {28'd0, red_vmask}, 32'hF);
            end else begin
               check("red_idle_op", {28'd0, red_valuop}, {28'd0, OP_ADD});
               check("red_idle_data", {31'd0, red_vdat == '0}, 32'd1);
            end
            if (rd_req) begin
               check("rd_req_expected", {31'd0, exp_running && exp_beat < exp_beats}, 32'd1);
               check("rd_idx", {25'd0, rd_idx}, exp_beat);
               if (wait_cnt >= rd_delay) begin
                  vbeat = exp_beat;
                  for (int i = 0; i < 4; i++) begin
                     rd_data[32*i +: 32] = elem[4*exp_beat + i];
                     rd_mask[i] = mbit[4*exp_beat + i];
                  end
                  rd_valid = 1'b1;
                  exp_beat++;
                  wait_cnt = 0;
               end else begin
                  wait_cnt++;
               end
            end
            if (out_valid) begin
               check("out_valid_expected", {31'd0, exp_running}, 32'd1);
               check("out_data", out_data, exp_data);
               check("out_wen", {31'd0, out_wen}, {31'd0, exp_wen});
               check("out_err", {31'd0, out_err}, {31'd0, exp_err});
               check("busy_done", {31'd0, busy}, 32'd1);
            end
            if (!exp_running) check("idle_busy", {31'd0, busy}, 32'd0);
         end
      end
   end

   task automatic run_instr(input logic [3:0] op, input bit u, input bit v, input int n,
                            input logic [31:0] sc, input int rdly, input int odly,
                            input logic [31:0] lit);
      int cyc;
      bit sup;
      sup = (op <= OP_XOR);
      cur_op = op; cur_uns = u; cur_vm = v; cur_vl = n;
      exp_data = model(op, u, v, n, sc);
      exp_err = !sup;
      exp_wen = sup && n != 0;
      exp_beats = sup ? (n + 3) / 4 : 0;
      exp_beat = 0; wait_cnt = 0; rd_delay = rdly; reads = 0;
      exp_running = 1'b1;
      check("model_vs_literal", exp_data, lit);
      @(negedge CLK);
      valuop = op; vopunsigned = u; vm = v; vl = 8'(n); scalar_in = sc; start = 1'b1;
      @(negedge CLK);
      start = 1'b0; valuop = ~op; vopunsigned = ~u; vm = ~v; vl = ~8'(n); scalar_in = ~sc;
      cyc = 0;
      while (!out_valid && cyc < 1000) begin
         @(negedge CLK);
         cyc++;
      end
      check("done_reached", {31'd0, cyc < 1000}, 32'd1);
      check("latency", cyc, exp_beats * (rdly + 2));
      check("out_data_literal", out_data, lit);
      check("read_count", reads, exp_beats);
      start = (odly > 0);
      for (int k = 0; k < odly; k++) begin
         @(negedge CLK);
         check("hold_valid", {31'd0, out_valid}, 32'd1);
         check("hold_data", out_data, lit);
      end
      out_ready = 1'b1;
      @(negedge CLK);
      out_ready = 1'b0;
      start = 1'b0;
      check("complete_valid", {31'd0, out_valid}, 32'd0);
      check("complete_busy", {31'd0, busy}, 32'd0);
      exp_running = 1'b0;
   endtask

   initial begin
      int cyc;
      clear_mem();
      repeat (3) @(negedge CLK);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rd_req", {31'd0, rd_req}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_wen", {31'd0, out_wen}, 32'd0);
      check("rst_out_err", {31'd0, out_err}, 32'd0);
      check("rst_rd_idx", {25'd0, rd_idx}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      RST = 1'b0;
      @(negedge CLK);

      // ADD with a partial tail beat
      clear_mem();
      elem[0] = 1; elem[1] = 2; elem[2] = 3; elem[3] = 4;
      elem[4] = 5; elem[5] = 6; elem[6] = 99; elem[7] = 99;
      run_instr(OP_ADD, 1'b0, 1'b1, 6, 32'd10, 0, 0, 32'd31);

      // signed MAX under a v0 mask
      clear_mem();
      elem[0] = 32'hFFFF_FFF0; elem[1] = 32'h7FFF_FFFF; elem[2] = 32'hFFFF_FFF8; elem[3] = 32'd5;
      mbit[0] = 1; mbit[1] = 0; mbit[2] = 1; mbit[3] = 0;
      run_instr(OP_MAX, 1'b0, 1'b0, 4, 32'hFFFF_FF00, 0, 0, 32'hFFFF_FFF8);

      // MINU with slow VRF reads
      clear_mem();
      elem[0] = 50; elem[1] = 40; elem[2] = 30; elem[3] = 20; elem[4] = 25;
      elem[5] = 60; elem[6] = 70; elem[7] = 80; elem[8] = 15;
      elem[9] = 1; elem[10] = 1; elem[11] = 1;
      run_instr(OP_MIN, 1'b1, 1'b1, 9, 32'hFFFF_FFFF, 3, 0, 32'd15);

      // vl = 0 and unsupported op go straight to DONE
      clear_mem();
      run_instr(OP_ADD, 1'b0, 1'b1, 0, 32'd7, 0, 0, 32'd7);
      run_instr(4'd9, 1'b0, 1'b1, 4, 32'h0000_1234, 0, 0, 32'h0000_1234);

      // signed MIN with a fully masked first beat
      clear_mem();
      for (int k = 0; k < 4; k++) elem[k] = 32'hFFFF_FC18;
      elem[4] = 32'hFFFF_FFFE; elem[5] = 32'd50; elem[6] = 32'd7; elem[7] = 32'hFFFF_FFFB;
      mbit[4] = 1; mbit[5] = 1;
      run_instr(OP_MIN, 1'b0, 1'b0, 8, 32'd100, 0, 0, 32'hFFFF_FFFE);

      // abort during ACCUM of beat 1 of 3
      clear_mem();
      cur_op = OP_XOR; cur_uns = 0; cur_vm = 1; cur_vl = 12;
      exp_beats = 3; exp_beat = 0; wait_cnt = 0; rd_delay = 0; reads = 0;
      exp_data = 32'hxxxx_xxxx; exp_wen = 0; exp_err = 0;
      exp_running = 1'b1;
      @(negedge CLK);
      valuop = OP_XOR; vopunsigned = 0; vm = 1; vl = 8'd12; scalar_in = 32'h1111_1111; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      #1;
      cyc = 0;
      while (!(rd_valid && vbeat == 1) && cyc < 100) begin
         @(negedge CLK);
         #1;
         cyc++;
      end
      check("abort_beat1_reached", {31'd0, cyc < 100}, 32'd1);
      @(negedge CLK);
      abort = 1'b1;
      @(negedge CLK);
      abort = 1'b0;
      exp_running = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_rd_req", {31'd0, rd_req}, 32'd0);
      repeat (4) @(negedge CLK);

      clear_mem();
      elem[0] = 32'h1; elem[1] = 32'h2; elem[2] = 32'h4; elem[3] = 32'h8; elem[4] = 32'h10;
      elem[5] = 32'hFFFF_0000; elem[6] = 32'hFFFF_0000; elem[7] = 32'hFFFF_0000;
      mbit[0] = 1; mbit[1] = 0; mbit[2] = 1; mbit[3] = 1; mbit[4] = 1; mbit[5] = 1;
      run_instr(OP_XOR, 1'b0, 1'b0, 5, 32'hA5A5_A5A5, 0, 0, 32'hA5A5_A5B8);

      // consumer stalls for 5 cycles with start held high
      clear_mem();
      elem[0] = 32'hF0F0_FFFF; elem[1] = 32'hFFFF_FFF3; elem[2] = 32'h0FFF_FFFF; elem[3] = 32'h0;
      run_instr(OP_AND, 1'b0, 1'b1, 3, 32'hFFFF_00FF, 1, 5, 32'h00F0_00F3);

      repeat (3) @(negedge CLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
